// File: rtl/simple_circuit_sweep_ctrl.sv
// Pseudo-random input-vector sequencer for simple_circuit evaluation; counts vectors producing f=1.
// Optional signature register and sig_out port under `SWEEP_SIGNATURE_EN.
module simple_circuit_sweep_ctrl #(
  parameter int N_IN    = 230,
  parameter int SETTLE  = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [COUNT_W-1:0] num_vectors,
  input  logic [31:0]        seed,
  input  logic               f_in,
  output logic [N_IN-1:0]    vec_out,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] vec_idx,
`ifdef SWEEP_SIGNATURE_EN
  output logic [15:0]        sig_out,
`endif
  output logic [COUNT_W-1:0] ones_count
);

  localparam int WORDS = (N_IN + 31) / 32;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SW    = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_APPLY, S_SAMPLE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic [32*WORDS-1:0]    stg_q, stg_d;
  logic [N_IN-1:0]        vec_q, vec_d;
  logic [COUNT_W-1:0]     num_q, num_d;
  logic [COUNT_W-1:0]     idx_q, idx_d;
  logic [COUNT_W-1:0]     ones_q, ones_d;
  logic [WW-1:0]          w_q, w_d;
  logic [SW-1:0]          st_q, st_d;
`ifdef SWEEP_SIGNATURE_EN
  logic [15:0]            sig_q, sig_d;
`endif

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    stg_d   = stg_q;
    vec_d   = vec_q;
    num_d   = num_q;
    idx_d   = idx_q;
    ones_d  = ones_q;
    w_d     = w_q;
    st_d    = st_q;
`ifdef SWEEP_SIGNATURE_EN
    sig_d   = sig_q;
`endif
    // abort freezes everything except the state, which drops straight to IDLE
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            num_d  = num_vectors;
            lfsr_d = (seed == 32'h0) ? 32'h1 : seed;
            idx_d  = '0;
            ones_d = '0;
            w_d    = '0;
`ifdef SWEEP_SIGNATURE_EN
            sig_d  = 16'h0;
`endif
            state_d = (num_vectors == '0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          stg_d[int'(w_q)*32 +: 32] = lfsr_q;
          lfsr_d = lfsr_next(lfsr_q);
          if (w_q == WW'(WORDS - 1)) begin
            // last word goes straight into vec_out along with the rest of staging
            vec_d   = stg_d[N_IN-1:0];
            st_d    = '0;
            state_d = S_APPLY;
          end else begin
            w_d = w_q + WW'(1);
          end
        end
        S_APPLY: begin
          if (st_q == SW'(SETTLE - 1)) state_d = S_SAMPLE;
          else                         st_d    = st_q + SW'(1);
        end
        S_SAMPLE: begin
          if (f_in && ones_q != {COUNT_W{1'b1}}) ones_d = ones_q + COUNT_W'(1);
          idx_d = idx_q + COUNT_W'(1);
`ifdef SWEEP_SIGNATURE_EN
          sig_d = (sig_q << 1) ^ (sig_q[15] ? 16'h1021 : 16'h0) ^ {15'b0, f_in};
`endif
          w_d = '0;
          state_d = (idx_q + COUNT_W'(1) == num_q) ? S_DONE : S_FILL;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= 32'h1;
      stg_q   <= '0;
      vec_q   <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      ones_q  <= '0;
      w_q     <= '0;
      st_q    <= '0;
`ifdef SWEEP_SIGNATURE_EN
      sig_q   <= 16'h0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      stg_q   <= stg_d;
      vec_q   <= vec_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      w_q     <= w_d;
      st_q    <= st_d;
`ifdef SWEEP_SIGNATURE_EN
      sig_q   <= sig_d;
`endif
    end
  end

  assign vec_out    = vec_q;
  assign vec_idx    = idx_q;
  assign ones_count = ones_q;
  assign busy       = (state_q == S_FILL) || (state_q == S_APPLY) || (state_q == S_SAMPLE);
  assign done       = (state_q == S_DONE);
`ifdef SWEEP_SIGNATURE_EN
  assign sig_out    = sig_q;
`endif

endmodule

// File: tb/tb_simple_circuit_sweep_ctrl.sv
// Scoreboard bench for simple_circuit_sweep_ctrl (default build and SWEEP_SIGNATURE_EN build).
module tb_simple_circuit_sweep_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, abort = 1'b0;
  logic [15:0]  num_vectors = '0;
  logic [31:0]  seed = '0;
  logic         f_in;
  logic [229:0] vec_out;
  logic         busy, done;
  logic [15:0]  vec_idx, ones_count;

  logic         start4 = 1'b0, abort4 = 1'b0, f4 = 1'b1;
  logic [3:0]   num4 = '0;
  logic [31:0]  seed4 = 32'h1234_5678;
  logic [229:0] vec_out4;
  logic         busy4, done4;
  logic [3:0]   idx4, ones4;
`ifdef SWEEP_SIGNATURE_EN
  logic [15:0]  sig_out, sig_out4;
`endif

  always #5 clk = ~clk;

  simple_circuit_sweep_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vectors(num_vectors),
    .seed(seed), .f_in(f_in), .vec_out(vec_out), .busy(busy), .done(done),
    .vec_idx(vec_idx),
`ifdef SWEEP_SIGNATURE_EN
    .sig_out(sig_out),
`endif
    .ones_count(ones_count)
  );

  simple_circuit_sweep_ctrl #(.COUNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .num_vectors(num4),
    .seed(seed4), .f_in(f4), .vec_out(vec_out4), .busy(busy4), .done(done4),
    .vec_idx(idx4),
`ifdef SWEEP_SIGNATURE_EN
    .sig_out(sig_out4),
`endif
    .ones_count(ones4)
  );

  typedef struct { logic [255:0] vec; logic [15:0] ones; } vexp_t;
  typedef struct { int ecyc; logic [15:0] idx; logic [15:0] ones; } rexp_t;

  vexp_t       vq[$];
  rexp_t       rq[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, c0 = 0, done_cnt = 0;
  bit          busy_seen = 1'b0;
  logic [31:0] fpat_cur = '0;
  logic [15:0] prev_idx = '0;

  assign f_in = fpat_cur[vec_idx[4:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_nx(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // expected vectors for the first n_push samples, and optionally the done result
  task automatic push_model(input int n_total, input int n_push, input logic [31:0] sd,
                            input logic [31:0] fp, input bit push_res);
    logic [31:0]  l;
    logic [255:0] full;
    logic [15:0]  ones;
    vexp_t        v;
    rexp_t        r;
    l    = (sd == 32'h0) ? 32'h1 : sd;
    ones = '0;
    for (int k = 0; k < n_push; k++) begin
      for (int w = 0; w < 8; w++) begin
        full[32*w +: 32] = l;
        l = lfsr_nx(l);
      end
      full[255:230] = '0;
      if (fp[k]) ones++;
      v.vec  = full;
      v.ones = ones;
      vq.push_back(v);
    end
    if (push_res) begin
      r.ecyc = 1 + 11 * n_total;
      r.idx  = 16'(n_total);
      r.ones = ones;
      rq.push_back(r);
    end
  endtask

  task automatic launch(input logic [15:0] nv, input logic [31:0] sd);
    @(negedge clk);
    num_vectors = nv;
    seed        = sd;
    start       = 1'b1;
    c0          = cyc;
    busy_seen   = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0 = done_cnt;
    int k  = 0;
    while (done_cnt == n0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == n0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_cycle(input int c);
    int k = 0;
    while ((cyc - c0) < c && k < 1000) begin
      @(negedge clk);
      k++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (vec_idx == prev_idx + 16'd1) begin
        if (vq.size() == 0) chk("vec_unexpected", 0, 1);
        else begin
          vexp_t e;
          e = vq.pop_front();
          chk("vec_out", {26'b0, vec_out}, e.vec);
          chk("ones_run", ones_count, e.ones);
        end
      end
      if (done) begin
        done_cnt++;
        if (rq.size() == 0) chk("done_unexpected", 0, 1);
        else begin
          rexp_t r;
          r = rq.pop_front();
          chk("done_cycle", cyc - c0, r.ecyc);
          chk("vec_idx", vec_idx, r.idx);
          chk("ones_count", ones_count, r.ones);
          chk("busy_at_done", busy, 1'b0);
        end
      end
      if (busy) busy_seen = 1'b1;
      prev_idx = vec_idx;
    end else begin
      prev_idx = '0;
    end
  end

  initial begin
    int n0, k;
    repeat (3) @(negedge clk);
    chk("rst_vec_out", {26'b0, vec_out}, 256'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_vec_idx", vec_idx, 16'h0);
    chk("rst_ones", ones_count, 16'h0);
    rst = 1'b0;
    @(negedge clk);

    // single vector, seed 0 loads as 1
    fpat_cur = 32'hFFFF_FFFF;
    push_model(1, 1, 32'h0, fpat_cur, 1'b1);
    launch(16'd1, 32'h0);
    wait_done(40);
    chk("seed0_word0", vec_out[31:0], 32'h0000_0001);
    chk("seed0_word1", vec_out[63:32], 32'h8020_0003);

    // zero-length sweep
    fpat_cur = 32'h0;
    push_model(0, 0, 32'hDEAD_BEEF, fpat_cur, 1'b1);
    launch(16'd0, 32'hDEAD_BEEF);
    wait_done(20);
    chk("zero_busy_seen", busy_seen, 1'b0);
    chk("zero_vec_idx", vec_idx, 16'h0);

    // five vectors, alternating f, stray start mid-sweep
    fpat_cur = 32'h0000_0015;
    push_model(5, 5, 32'hACE1_2345, fpat_cur, 1'b1);
    launch(16'd5, 32'hACE1_2345);
    wait_cycle(20);
    num_vectors = 16'd2;
    seed        = 32'h0BAD_F00D;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(80);
    repeat (3) @(negedge clk);
    chk("hold_vec_idx", vec_idx, 16'd5);
    chk("hold_ones", ones_count, 16'd3);

    // abort mid second vector
    fpat_cur = 32'h0000_0001;
    push_model(3, 1, 32'h5555_AAAA, fpat_cur, 1'b0);
    launch(16'd3, 32'h5555_AAAA);
    n0 = done_cnt;
    wait_cycle(15);
    chk("pre_abort_busy", busy, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_vec_idx", vec_idx, 16'd1);
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt - n0, 0);
    chk("abort_queue_empty", vq.size(), 0);

    // start and abort together in IDLE: start ignored
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 1'b0);
    @(negedge clk);
    chk("start_abort_busy2", busy, 1'b0);
    chk("start_abort_done", done, 1'b0);

    // reset during the second vector's fill
    fpat_cur = 32'h0000_0003;
    push_model(2, 1, 32'h0F0F_1234, fpat_cur, 1'b0);
    launch(16'd2, 32'h0F0F_1234);
    wait_cycle(13);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_vec_out", {26'b0, vec_out}, 256'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_vec_idx", vec_idx, 16'h0);
    chk("mid_rst_ones", ones_count, 16'h0);
    vq.delete();
    rq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_done", done, 1'b0);

`ifdef SWEEP_SIGNATURE_EN
    fpat_cur = 32'hFFFF_FFFF;
    push_model(2, 2, 32'h0000_0077, fpat_cur, 1'b1);
    launch(16'd2, 32'h0000_0077);
    wait_done(50);
    chk("sig_out", sig_out, 16'h0003);
`endif

    // narrow counter instance: 15 vectors all f=1
    @(negedge clk);
    num4   = 4'd15;
    start4 = 1'b1;
    c0     = cyc;
    @(negedge clk);
    start4 = 1'b0;
    k = 0;
    while (!done4 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("w4_done_seen", done4, 1'b1);
    chk("w4_done_cycle", cyc - c0, 166);
    chk("w4_ones", ones4, 4'd15);
    chk("w4_idx", idx4, 4'd15);
    repeat (5) @(negedge clk);
    chk("w4_ones_hold", ones4, 4'd15);
    chk("w4_busy_idle", busy4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
